cp_issue_stage: RTL and testbench

- Issue/writeback stage directly upstream of the coprocessor compute unit.
- Accepts 32-bit coprocessor instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal 16x32 register file and drives the compute unit's rs1/rs2/immediate/operation inputs.
- After a fixed latency, writes the compute unit result back to the destination register and reports retirement.

---
 rtl/cp_issue_stage_pkg.sv | 43 ++++
 rtl/cp_regfile.sv | 40 ++++
 rtl/cp_issue_stage.sv | 179 +++++++++++++++++
 tb/tb_cp_issue_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_issue_stage_pkg.sv
// Shared definitions for the coprocessor issue stage.
// Provides the opcode encodings, the instruction field positions, the legal-opcode
// check, register-file geometry and the issue FSM state type.
package cp_issue_stage_pkg;

  // Instruction layout: op[31:28] rd[27:24] rs1[23:20] rs2[19:16] imm[15:0]
  localparam int unsigned INSTR_OP_LSB  = 28;
  localparam int unsigned INSTR_RD_LSB  = 24;
  localparam int unsigned INSTR_RS1_LSB = 20;
  localparam int unsigned INSTR_RS2_LSB = 16;
  localparam int unsigned INSTR_IMM_LSB = 0;

  localparam int unsigned REG_COUNT  = 16;
  localparam int unsigned REG_ADDR_W = 4;

  // Defined opcodes; encodings 4'hA..4'hF are illegal.
  localparam logic [3:0] OP_ADD         = 4'h0;
  localparam logic [3:0] OP_SUB         = 4'h1;
  localparam logic [3:0] OP_XOR         = 4'h2;
  localparam logic [3:0] OP_LOAD_LLI    = 4'h3;
  localparam logic [3:0] OP_LOAD_LUI    = 4'h4;
  localparam logic [3:0] OP_SHA256_SIG0 = 4'h5;
  localparam logic [3:0] OP_SHA256_SIG1 = 4'h6;
  localparam logic [3:0] OP_SHA256_SUM0 = 4'h7;
  localparam logic [3:0] OP_SHA256_SUM1 = 4'h8;
  localparam logic [3:0] OP_ROTR        = 4'h9;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb
  } cp_state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_LOAD_LLI, OP_LOAD_LUI,
      OP_SHA256_SIG0, OP_SHA256_SIG1, OP_SHA256_SUM0, OP_SHA256_SUM1,
      OP_ROTR:  return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cp_regfile.sv
// 16x32 register file for the coprocessor issue stage. R0 always reads 0.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low clear of all entries
//   i_raddr_a/o_rdata_a   asynchronous read port A (rs1)
//   i_raddr_b/o_rdata_b   asynchronous read port B (rs2)
//   i_raddr_d/o_rdata_d   asynchronous read port D (rd, for half-word loads)
//   i_we/i_waddr/i_wdata  synchronous write port; writes to R0 are dropped
module cp_regfile
  import cp_issue_stage_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_raddr_a,
  output logic [31:0]           o_rdata_a,
  input  logic [REG_ADDR_W-1:0] i_raddr_b,
  output logic [31:0]           o_rdata_b,
  input  logic [REG_ADDR_W-1:0] i_raddr_d,
  output logic [31:0]           o_rdata_d,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [31:0]           i_wdata
);

  logic [31:0] r_mem [REG_COUNT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];
  assign o_rdata_d = (i_raddr_d == '0) ? '0 : r_mem[i_raddr_d];

endmodule

// File: rtl/cp_issue_stage.sv
// Issue/writeback stage in front of the coprocessor compute unit.
// Accepts one instruction at a time, drives registered operands to the compute unit,
// waits CU_LATENCY+1 cycles, then writes cu_out back and pulses the retire outputs.
// Optional feature macro: CP_ISSUE_PERF_EN adds retired/illegal 32-bit counters.
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_instr_valid, i_instr, o_instr_ready   instruction handshake
//   o_cu_rs1, o_cu_rs2, o_cu_imm, o_cu_op   operands to the compute unit
//   i_cu_out                           compute unit result
//   o_retire_valid/_rd/_data/_illegal  retirement report (one-cycle pulse)
//   o_perf_retired, o_perf_illegal     event counters (CP_ISSUE_PERF_EN only)
module cp_issue_stage
  import cp_issue_stage_pkg::*;
#(
  parameter int unsigned CU_LATENCY = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instr,
  output logic        o_instr_ready,
  output logic [31:0] o_cu_rs1,
  output logic [31:0] o_cu_rs2,
  output logic [15:0] o_cu_imm,
  output logic [3:0]  o_cu_op,
  input  logic [31:0] i_cu_out,
  output logic        o_retire_valid,
  output logic [3:0]  o_retire_rd,
  output logic [31:0] o_retire_data,
  output logic        o_retire_illegal
`ifdef CP_ISSUE_PERF_EN
  ,
  output logic [31:0] o_perf_retired,
  output logic [31:0] o_perf_illegal
`endif
);

  localparam int unsigned CntW = (CU_LATENCY > 0) ? $clog2(CU_LATENCY + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(CU_LATENCY);

  cp_state_e       r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_ready;
  logic [3:0]      r_rd;
  logic            r_legal;
  logic [31:0]     r_cu_rs1;
  logic [31:0]     r_cu_rs2;
  logic [15:0]     r_cu_imm;
  logic [3:0]      r_cu_op;
  logic            r_retire_valid;
  logic [3:0]      r_retire_rd;
  logic [31:0]     r_retire_data;
  logic            r_retire_illegal;

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [3:0]  w_rs2;
  logic [15:0] w_imm;
  logic        w_is_load;
  logic        w_accept;
  logic        w_we;
  logic [31:0] w_rdata_a;
  logic [31:0] w_rdata_b;
  logic [31:0] w_rdata_d;

  assign w_op  = i_instr[INSTR_OP_LSB  +: 4];
  assign w_rd  = i_instr[INSTR_RD_LSB  +: 4];
  assign w_rs1 = i_instr[INSTR_RS1_LSB +: 4];
  assign w_rs2 = i_instr[INSTR_RS2_LSB +: 4];
  assign w_imm = i_instr[INSTR_IMM_LSB +: 16];

  // Half-word loads merge into rd, so the compute unit needs the current R[rd].
  assign w_is_load = (w_op == OP_LOAD_LLI) || (w_op == OP_LOAD_LUI);
  assign w_accept  = i_instr_valid && r_ready;
  assign w_we      = (r_state == StWb) && r_legal && (r_rd != 4'd0);

  cp_regfile u_regfile (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_raddr_a (w_rs1),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (w_rs2),
    .o_rdata_b (w_rdata_b),
    .i_raddr_d (w_rd),
    .o_rdata_d (w_rdata_d),
    .i_we      (w_we),
    .i_waddr   (r_rd),
    .i_wdata   (i_cu_out)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= StIdle;
      r_cnt            <= '0;
      r_ready          <= 1'b0;
      r_rd             <= '0;
      r_legal          <= 1'b0;
      r_cu_rs1         <= '0;
      r_cu_rs2         <= '0;
      r_cu_imm         <= '0;
      r_cu_op          <= '0;
      r_retire_valid   <= 1'b0;
      r_retire_rd      <= '0;
      r_retire_data    <= '0;
      r_retire_illegal <= 1'b0;
    end else begin
      r_retire_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_rd     <= w_rd;
            r_legal  <= op_is_legal(w_op);
            r_cu_rs1 <= w_is_load ? w_rdata_d : w_rdata_a;
            r_cu_rs2 <= w_is_load ? {16'h0, w_imm} : w_rdata_b;
            r_cu_imm <= w_imm;
            r_cu_op  <= w_op;
            r_cnt    <= CntInit;
            r_ready  <= 1'b0;
            r_state  <= StExec;
          end else begin
            // Also raises ready in the first cycle after reset release.
            r_ready <= 1'b1;
          end
        end
        StExec: begin
          if (r_cnt == '0) begin
            r_state <= StWb;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StWb: begin
          r_retire_valid   <= 1'b1;
          r_retire_rd      <= r_rd;
          r_retire_data    <= r_legal ? i_cu_out : 32'h0;
          r_retire_illegal <= ~r_legal;
          r_ready          <= 1'b1;
          r_state          <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_instr_ready    = r_ready;
  assign o_cu_rs1         = r_cu_rs1;
  assign o_cu_rs2         = r_cu_rs2;
  assign o_cu_imm         = r_cu_imm;
  assign o_cu_op          = r_cu_op;
  assign o_retire_valid   = r_retire_valid;
  assign o_retire_rd      = r_retire_rd;
  assign o_retire_data    = r_retire_data;
  assign o_retire_illegal = r_retire_illegal;

`ifdef CP_ISSUE_PERF_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_illegal;

  // Counted at the WB edge, so the new value is visible alongside the retire pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_retired <= '0;
      r_perf_illegal <= '0;
    end else if (r_state == StWb) begin
      r_perf_retired <= r_perf_retired + 32'd1;
      if (!r_legal) begin
        r_perf_illegal <= r_perf_illegal + 32'd1;
      end
    end
  end

  assign o_perf_retired = r_perf_retired;
  assign o_perf_illegal = r_perf_illegal;
`endif

endmodule

// File: tb/tb_cp_issue_stage.sv
// Self-checking bench for cp_issue_stage with CU_LATENCY=2 and a behavioural
// compute-unit model. A reference register file and retire counters track the
// expected architectural state.
module tb_cp_issue_stage;
  import cp_issue_stage_pkg::*;

  localparam int unsigned Lat = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        instr_ready;
  logic [31:0] cu_rs1, cu_rs2;
  logic [15:0] cu_imm;
  logic [3:0]  cu_op;
  logic [31:0] cu_out;
  logic        retire_valid;
  logic [3:0]  retire_rd;
  logic [31:0] retire_data;
  logic        retire_illegal;
`ifdef CP_ISSUE_PERF_EN
  logic [31:0] perf_retired, perf_illegal;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ref_rf [16];
  int ref_retired = 0;
  int ref_illegal = 0;
  logic        cu_force = 1'b0;
  logic [31:0] cu_force_val = 32'h0;

  always #5 clk = ~clk;

  cp_issue_stage #(.CU_LATENCY(Lat)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_instr_valid    (instr_valid),
    .i_instr          (instr),
    .o_instr_ready    (instr_ready),
    .o_cu_rs1         (cu_rs1),
    .o_cu_rs2         (cu_rs2),
    .o_cu_imm         (cu_imm),
    .o_cu_op          (cu_op),
    .i_cu_out         (cu_out),
    .o_retire_valid   (retire_valid),
    .o_retire_rd      (retire_rd),
    .o_retire_data    (retire_data),
    .o_retire_illegal (retire_illegal)
`ifdef CP_ISSUE_PERF_EN
    ,
    .o_perf_retired   (perf_retired),
    .o_perf_illegal   (perf_illegal)
`endif
  );

  // Compute unit stand-in: half-word merges for the loads, an arbitrary mix otherwise.
  function automatic logic [31:0] cu_model(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [15:0] imm);
    if (op == OP_LOAD_LLI) return {a[31:16], imm};
    if (op == OP_LOAD_LUI) return {imm, a[15:0]};
    return (a ^ {b[15:0], b[31:16]}) + {16'h0, imm} + {28'h0, op};
  endfunction

  always_comb begin
    cu_out = cu_force ? cu_force_val : cu_model(cu_op, cu_rs1, cu_rs2, cu_imm);
  end

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) ref_rf[i] = 32'h0;
    ref_retired = 0;
    ref_illegal = 0;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (dut.u_regfile.r_mem[i] !== ref_rf[i]) begin
        n_err++;
        $display("FAIL %s R%0d: got %h want %h", tag, i, dut.u_regfile.r_mem[i], ref_rf[i]);
      end
    end
  endtask

  // Issues one instruction with instr_valid held until the retire pulse, checking
  // operands, exact latency, ready pattern and retire fields against the model.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [15:0] imm,
                       output logic [31:0] act_rs1, output logic [31:0] act_data,
                       output logic act_ill);
    logic [31:0] ea, eb, eres, edata;
    logic        eill, is_load, want;
    is_load = (op == OP_LOAD_LLI) || (op == OP_LOAD_LUI);
    ea      = is_load ? ref_rf[rd] : ref_rf[rs1];
    eb      = is_load ? {16'h0, imm} : ref_rf[rs2];
    eill    = (op > 4'd9);
    eres    = cu_force ? cu_force_val : cu_model(op, ea, eb, imm);
    edata   = eill ? 32'h0 : eres;

    @(negedge clk);
    instr       = {op, rd, rs1, rs2, imm};
    instr_valid = 1'b1;
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_idle: got %b want 1", instr_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({cu_rs1, cu_rs2, cu_imm, cu_op} !== {ea, eb, imm, op}) begin
      n_err++;
      $display("FAIL cu_operands: got %h %h %h %h want %h %h %h %h",
               cu_rs1, cu_rs2, cu_imm, cu_op, ea, eb, imm, op);
    end
    act_rs1 = cu_rs1;
    for (int c = 1; c <= Lat + 3; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      want = (c == Lat + 3);
      n_cmp++;
      if (instr_ready !== want) begin
        n_err++;
        $display("FAIL ready_cycle%0d: got %b want %b", c, instr_ready, want);
      end
      n_cmp++;
      if (retire_valid !== want) begin
        n_err++;
        $display("FAIL retire_valid_cycle%0d: got %b want %b", c, retire_valid, want);
      end
    end
    instr_valid = 1'b0;
    n_cmp++;
    if ({retire_rd, retire_data, retire_illegal} !== {rd, edata, eill}) begin
      n_err++;
      $display("FAIL retire_fields: got rd=%0d data=%h ill=%b want rd=%0d data=%h ill=%b",
               retire_rd, retire_data, retire_illegal, rd, edata, eill);
    end
    act_data = retire_data;
    act_ill  = retire_illegal;
    if (!eill && rd != 4'd0) ref_rf[rd] = eres;
    ref_retired++;
    if (eill) ref_illegal++;
`ifdef CP_ISSUE_PERF_EN
    n_cmp++;
    if (perf_retired !== 32'(ref_retired) || perf_illegal !== 32'(ref_illegal)) begin
      n_err++;
      $display("FAIL perf_counts: got %0d/%0d want %0d/%0d",
               perf_retired, perf_illegal, ref_retired, ref_illegal);
    end
`endif
  endtask

  task automatic test_reset();
    clear_ref();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (instr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 0", instr_ready);
    end
    n_cmp++;
    if ({cu_rs1, cu_rs2, cu_imm, cu_op} !== 84'h0) begin
      n_err++;
      $display("FAIL reset_cu: got %h %h %h %h want 0", cu_rs1, cu_rs2, cu_imm, cu_op);
    end
    n_cmp++;
    if ({retire_valid, retire_rd, retire_data, retire_illegal} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_retire: got %b %h %h %b want 0",
               retire_valid, retire_rd, retire_data, retire_illegal);
    end
    check_rf("reset_rf");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release_ready: got %b want 1", instr_ready);
    end
  endtask

  task automatic test_load_halves();
    logic [31:0] rs1v, data;
    logic        ill;
    issue(OP_LOAD_LLI, 4'd1, 4'd0, 4'd0, 16'h1234, rs1v, data, ill);
    n_cmp++;
    if (data !== 32'h00001234) begin
      n_err++;
      $display("FAIL lli_data: got %h want 00001234", data);
    end
    issue(OP_LOAD_LUI, 4'd1, 4'd0, 4'd0, 16'hABCD, rs1v, data, ill);
    n_cmp++;
    if (rs1v !== 32'h00001234) begin
      n_err++;
      $display("FAIL lui_cu_rs1: got %h want 00001234", rs1v);
    end
    n_cmp++;
    if (data !== 32'hABCD1234) begin
      n_err++;
      $display("FAIL lui_data: got %h want abcd1234", data);
    end
    n_cmp++;
    if (dut.u_regfile.r_mem[1] !== 32'hABCD1234) begin
      n_err++;
      $display("FAIL lui_r1: got %h want abcd1234", dut.u_regfile.r_mem[1]);
    end
  endtask

  task automatic test_sig0();
    logic [31:0] rs1v, data;
    logic        ill;
    cu_force     = 1'b1;
    cu_force_val = 32'hDEADBEEF;
    issue(OP_SHA256_SIG0, 4'd2, 4'd1, 4'd0, 16'h0000, rs1v, data, ill);
    cu_force = 1'b0;
    n_cmp++;
    if (rs1v !== 32'hABCD1234) begin
      n_err++;
      $display("FAIL sig0_cu_rs1: got %h want abcd1234", rs1v);
    end
    n_cmp++;
    if (data !== 32'hDEADBEEF || ill !== 1'b0) begin
      n_err++;
      $display("FAIL sig0_retire: got %h ill=%b want deadbeef ill=0", data, ill);
    end
    check_rf("sig0_rf");
  endtask

  task automatic test_illegal();
    logic [31:0] rs1v, data;
    logic        ill;
    issue(4'hF, 4'd3, 4'd1, 4'd2, 16'h5555, rs1v, data, ill);
    n_cmp++;
    if (data !== 32'h0 || ill !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_retire: got %h ill=%b want 0 ill=1", data, ill);
    end
    n_cmp++;
    if (dut.u_regfile.r_mem[3] !== 32'h0) begin
      n_err++;
      $display("FAIL illegal_r3: got %h want 0", dut.u_regfile.r_mem[3]);
    end
  endtask

  task automatic test_rd_zero();
    logic [31:0] rs1v, data;
    logic        ill;
    issue(OP_ADD, 4'd0, 4'd1, 4'd2, 16'h0042, rs1v, data, ill);
    issue(OP_XOR, 4'd4, 4'd0, 4'd0, 16'h0005, rs1v, data, ill);
    n_cmp++;
    if (rs1v !== 32'h0) begin
      n_err++;
      $display("FAIL r0_read: got %h want 0", rs1v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rs1v, data;
    logic        ill;
    issue(OP_ADD, 4'd5, 4'd1, 4'd2, 16'h0101, rs1v, data, ill);
    issue(OP_SUB, 4'd6, 4'd5, 4'd5, 16'h0202, rs1v, data, ill);
    issue(OP_ROTR, 4'd5, 4'd6, 4'd5, 16'h0303, rs1v, data, ill);
    check_rf("b2b_rf");
  endtask

  task automatic test_random();
    logic [31:0] rs1v, data;
    logic        ill;
    for (int n = 0; n < 40; n++) begin
      issue(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
            4'($urandom_range(15, 0)), 16'($urandom), rs1v, data, ill);
    end
    check_rf("random_rf");
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    instr       = {OP_LOAD_LLI, 4'd7, 4'd0, 4'd0, 16'h7777};
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_ref();
    #1;
    n_cmp++;
    if (instr_ready !== 1'b0 || retire_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got ready=%b rv=%b want 0 0", instr_ready, retire_valid);
    end
    check_rf("midreset_rf");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= Lat + 4; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (retire_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_no_retire_cycle%0d: got %b want 0", c, retire_valid);
      end
      if (c == 1) begin
        n_cmp++;
        if (instr_ready !== 1'b1) begin
          n_err++;
          $display("FAIL midreset_ready: got %b want 1", instr_ready);
        end
      end
    end
    check_rf("post_midreset_rf");
  endtask

  initial begin
    test_reset();
    test_load_halves();
    test_sig0();
    test_illegal();
    test_rd_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    test_load_halves();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
